// File: rtl/exibidor_sequencia.sv
// Plays the stored color sequence on the RGB LEDs for the game FSM:
// each element is shown for t_on cycles, then blanked for t_off cycles.
module exibidor_sequencia #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 12,
    parameter int T_ON   = 1000,
    parameter int T_OFF  = 500
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              modo_rapido,
    input  logic [ADDR_W-1:0] limite,
    input  logic [3:0]        mem_dado,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        leds,
    output logic              busy,
    output logic              done,
    output logic [2:0]        db_estado
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ON   = 3'd2,
        OFF  = 3'd3,
        NEXT = 3'd4,
        FIM  = 3'd5
    } state_t;

    // Terminal counts are kept as "duration minus one" so the counter compares directly.
    localparam logic [CNT_W-1:0] ON_LAST_NORM  = CNT_W'(T_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LAST_NORM = CNT_W'(T_OFF - 1);
    localparam logic [CNT_W-1:0] ON_LAST_FAST  = CNT_W'((T_ON >> 1) - 1);
    localparam logic [CNT_W-1:0] OFF_LAST_FAST = CNT_W'((T_OFF >> 1) - 1);

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_memAddr;
    logic [ADDR_W-1:0] r_lim;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_onLast;
    logic [CNT_W-1:0]  r_offLast;
    logic [3:0]        r_cor;
    logic              w_onEnd;
    logic              w_offEnd;
    logic              w_abortRun;

    assign w_onEnd    = (r_cnt == r_onLast);
    assign w_offEnd   = (r_cnt == r_offLast);
    assign w_abortRun = abort && (r_state != IDLE);

    always_comb begin
        w_nextState = IDLE;
        case (r_state)
            IDLE:    w_nextState = (start && !abort) ? LOAD : IDLE;
            LOAD:    w_nextState = ON;
            ON:      w_nextState = w_onEnd ? OFF : ON;
            OFF: begin
                if (!w_offEnd)
                    w_nextState = OFF;
                else if (r_memAddr == r_lim)
                    w_nextState = FIM;
                else
                    w_nextState = NEXT;
            end
            NEXT:    w_nextState = LOAD;
            FIM:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
        if (abort)
            w_nextState = IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_memAddr <= '0;
            r_lim     <= '0;
            r_cnt     <= '0;
            r_onLast  <= ON_LAST_NORM;
            r_offLast <= OFF_LAST_NORM;
            r_cor     <= '0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    r_memAddr <= '0;
                    r_cnt     <= '0;
                    if (start && !abort) begin
                        r_lim     <= limite;
                        r_onLast  <= modo_rapido ? ON_LAST_FAST  : ON_LAST_NORM;
                        r_offLast <= modo_rapido ? OFF_LAST_FAST : OFF_LAST_NORM;
                    end
                end
                LOAD: begin
                    r_cor <= mem_dado;
                    r_cnt <= '0;
                end
                ON:      r_cnt <= w_onEnd  ? '0 : r_cnt + CNT_W'(1);
                OFF:     r_cnt <= w_offEnd ? '0 : r_cnt + CNT_W'(1);
                NEXT:    r_memAddr <= r_memAddr + ADDR_W'(1);
                FIM:     r_memAddr <= '0;
                default: r_memAddr <= '0;
            endcase
            // A cancelled run must leave the address and counter ready for a fresh start.
            if (w_abortRun) begin
                r_memAddr <= '0;
                r_cnt     <= '0;
            end
        end
    end

    assign mem_addr  = r_memAddr;
    assign leds      = (r_state == ON) ? r_cor : 4'd0;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == FIM) && !abort;
    assign db_estado = r_state;

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Randomized, self-checking bench for exibidor_sequencia against a timeline
// model: every output is derived from the cycle offset since the accepted start.
module tb_exibidor_sequencia;

    localparam int TON  = 4;
    localparam int TOFF = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       modo_rapido;
    logic [3:0] limite;
    logic [3:0] mem_dado;
    logic [3:0] mem_addr;
    logic [3:0] leds;
    logic       busy;
    logic       done;
    logic [2:0] db_estado;

    logic [3:0] memArr [0:15];

    int assertCount = 0;
    int failCount   = 0;
    int busyCount   = 0;
    int doneCount   = 0;
    int ledsCount   = 0;

    // Model of the run: active flag, offset since LOAD, latched limit and intervals.
    bit mActive = 1'b0;
    int mD      = 0;
    int mLim    = 0;
    int mTon    = TON;
    int mToff   = TOFF;

    exibidor_sequencia #(
        .ADDR_W(4),
        .CNT_W (12),
        .T_ON  (TON),
        .T_OFF (TOFF)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .modo_rapido(modo_rapido),
        .limite     (limite),
        .mem_dado   (mem_dado),
        .mem_addr   (mem_addr),
        .leds       (leds),
        .busy       (busy),
        .done       (done),
        .db_estado  (db_estado)
    );

    assign mem_dado = memArr[mem_addr];

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Expected outputs follow from the phase inside the current element's period.
    task automatic compareModel();
        int p, e, r, eLeds, eAddr, eBusy, eDone, eState;
        eLeds = 0; eAddr = 0; eBusy = 0; eDone = 0; eState = 0;
        if (mActive) begin
            p     = mTon + mToff + 2;
            e     = mD / p;
            r     = mD % p;
            eBusy = 1;
            eAddr = e;
            if (r == 0)
                eState = 1;
            else if (r <= mTon) begin
                eState = 2;
                eLeds  = memArr[e];
            end else if (r <= mTon + mToff)
                eState = 3;
            else
                eState = (e == mLim) ? 5 : 4;
            eDone = (eState == 5 && !abort) ? 1 : 0;
        end
        checkOutput("leds", int'(leds), eLeds);
        checkOutput("mem_addr", int'(mem_addr), eAddr);
        checkOutput("busy", int'(busy), eBusy);
        checkOutput("done", int'(done), eDone);
        checkOutput("db_estado", int'(db_estado), eState);
        if (busy) busyCount++;
        if (done) doneCount++;
        if (leds != 4'd0) ledsCount++;
    endtask

    task automatic updateModel();
        if (!reset)
            mActive = 1'b0;
        else if (mActive) begin
            if (abort)
                mActive = 1'b0;
            else begin
                mD++;
                if (mD == (mLim + 1) * (mTon + mToff + 2))
                    mActive = 1'b0;
            end
        end else if (start && !abort) begin
            mActive = 1'b1;
            mD      = 0;
            mLim    = int'(limite);
            mTon    = modo_rapido ? (TON >> 1)  : TON;
            mToff   = modo_rapido ? (TOFF >> 1) : TOFF;
        end
    endtask

    // One clock: compare mid-cycle, advance the model on the edge, resume just after it.
    task automatic tick();
        @(negedge clock);
        if (!reset) mActive = 1'b0;
        compareModel();
        @(posedge clock);
        updateModel();
        #1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) tick();
    endtask

    task automatic applyStimulus(input int lim, input bit fast);
        limite      = 4'(lim);
        modo_rapido = fast;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic checkRunCounts(input string tag, input int b0, input int d0, input int l0,
                                  input int expBusy, input int expDone, input int expLeds);
        checkOutput({tag, "_busyCycles"}, busyCount - b0, expBusy);
        checkOutput({tag, "_doneCount"}, doneCount - d0, expDone);
        checkOutput({tag, "_ledsCycles"}, ledsCount - l0, expLeds);
    endtask

    initial begin
        int b0, d0, l0, abortAt, cnt;
        reset = 1'b0; start = 1'b0; abort = 1'b0; modo_rapido = 1'b0; limite = '0;
        for (int i = 0; i < 16; i++) memArr[i] = 4'd0;
        #3;
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_leds", int'(leds), 0);
        checkOutput("rst_state", int'(db_estado), 0);
        checkOutput("rst_addr", int'(mem_addr), 0);
        checkOutput("rst_done", int'(done), 0);
        waitCycles(2);
        reset = 1'b1;
        waitCycles(2);

        $display("[TB] single element, normal speed");
        memArr[0] = 4'b0001;
        b0 = busyCount; d0 = doneCount; l0 = ledsCount;
        applyStimulus(0, 1'b0);
        checkOutput("s1_loadState", int'(db_estado), 1);
        tick();
        checkOutput("s1_firstLeds", int'(leds), 1);
        waitCycles(10);
        checkRunCounts("s1", b0, d0, l0, 8, 1, 4);

        $display("[TB] three elements");
        memArr[0] = 4'b0001; memArr[1] = 4'b0010; memArr[2] = 4'b0100;
        b0 = busyCount; d0 = doneCount; l0 = ledsCount;
        applyStimulus(2, 1'b0);
        waitCycles(27);
        checkRunCounts("s2", b0, d0, l0, 24, 1, 12);
        checkOutput("s2_addrAfter", int'(mem_addr), 0);

        $display("[TB] fast mode");
        b0 = busyCount; d0 = doneCount; l0 = ledsCount;
        applyStimulus(0, 1'b1);
        modo_rapido = 1'b0;
        tick();
        modo_rapido = 1'b1;
        tick();
        modo_rapido = 1'b0;
        waitCycles(5);
        checkRunCounts("s3", b0, d0, l0, 5, 1, 2);

        $display("[TB] abort during element 1");
        d0 = doneCount;
        applyStimulus(2, 1'b0);
        waitCycles(10);
        checkOutput("s4_inOnElem1", int'(db_estado), 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("s4_busyAfter", int'(busy), 0);
        checkOutput("s4_addrAfter", int'(mem_addr), 0);
        checkOutput("s4_ledsAfter", int'(leds), 0);
        waitCycles(3);
        checkOutput("s4_noDone", doneCount - d0, 0);
        applyStimulus(2, 1'b0);
        tick();
        checkOutput("s4_replayAddr", int'(mem_addr), 0);
        checkOutput("s4_replayLeds", int'(leds), 1);
        waitCycles(26);

        $display("[TB] ignored inputs while busy");
        b0 = busyCount; d0 = doneCount; l0 = ledsCount;
        applyStimulus(2, 1'b0);
        for (int i = 0; i < 20; i++) begin
            start  = (i % 3 == 0);
            limite = (i >= 4) ? 4'd0 : 4'd2;
            tick();
        end
        start = 1'b0;
        waitCycles(8);
        checkRunCounts("s5", b0, d0, l0, 24, 1, 12);

        $display("[TB] reset mid-run");
        applyStimulus(0, 1'b0);
        waitCycles(5);
        checkOutput("s6_inOff", int'(db_estado), 3);
        reset = 1'b0;
        #1;
        checkOutput("s6_busy", int'(busy), 0);
        checkOutput("s6_state", int'(db_estado), 0);
        checkOutput("s6_leds", int'(leds), 0);
        waitCycles(2);
        reset = 1'b1;
        tick();
        b0 = busyCount; d0 = doneCount; l0 = ledsCount;
        applyStimulus(0, 1'b0);
        waitCycles(10);
        checkRunCounts("s6", b0, d0, l0, 8, 1, 4);

        $display("[TB] randomized runs");
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 16; i++) memArr[i] = 4'($urandom_range(0, 15));
            abortAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : -1;
            applyStimulus(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
            cnt = 0;
            while (mActive && cnt < 400) begin
                start       = 1'($urandom_range(0, 1));
                limite      = 4'($urandom_range(0, 15));
                modo_rapido = 1'($urandom_range(0, 1));
                abort       = (cnt == abortAt);
                tick();
                cnt++;
            end
            start = 1'b0;
            abort = 1'b0;
            if (mActive) checkOutput("runTimeout", 1, 0);
            waitCycles($urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
